// File: rtl/dsp_unpack_v4.sv
// Serialises a packed four-lane 48-bit DSP result into a narrow valid/ready
// stream of enabled lanes, lowest lane first, with no bubble between words.
module dsp_unpack_v4 #(
  parameter int width = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic [3:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last
);

  generate
    if (width < 1 || width > 12) begin : g_bad_width
      $error("dsp_unpack_v4: width must be in 1..12");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_reg, state_next;
  logic [47:0] data_reg, data_next;
  logic [3:0]  mask_reg, mask_next;
  logic [1:0]  ptr_reg, ptr_next;

  logic [11:0] lane_w [4];
  logic [1:0]  first_in;
  logic [1:0]  next_ptr;
  logic        last_w;
  logic        in_xfer;
  logic        out_xfer;
  logic        load;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_w[gi] = data_reg[12*gi +: 12];
  end

  // Lowest enabled lane of the incoming word, and the next enabled lane
  // above the current pointer in the held word.
  always_comb begin
    first_in = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (in_mask[i]) first_in = 2'(i);
    end
    next_ptr = ptr_reg;
    last_w   = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (mask_reg[i] && (2'(i) > ptr_reg)) begin
        next_ptr = 2'(i);
        last_w   = 1'b0;
      end
    end
  end

  assign out_valid = (state_reg == EMIT);
  assign out_lane  = out_valid ? ptr_reg : 2'd0;
  assign out_last  = out_valid && last_w;
  assign out_data  = out_valid ? lane_w[ptr_reg][width-1:0] : '0;
  assign in_ready  = (state_reg == IDLE) || (last_w && out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign load     = in_xfer && (in_mask != 4'd0);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    mask_next  = mask_reg;
    ptr_next   = ptr_reg;
    unique case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = EMIT;
          data_next  = in_data;
          mask_next  = in_mask;
          ptr_next   = first_in;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (!last_w) begin
            ptr_next = next_ptr;
          end else if (load) begin
            // Last lane leaves while the next word arrives: chain directly.
            data_next = in_data;
            mask_next = in_mask;
            ptr_next  = first_in;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      mask_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      mask_reg  <= mask_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_dsp_unpack_v4.sv
// Randomised and directed bench for dsp_unpack_v4; a queue of pending lanes
// serves as the reference model, with full and 8-bit lane widths side by side.
module tb_dsp_unpack_v4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_last;
  logic [11:0] out_data;
  logic [1:0]  out_lane;
  logic        in_ready8, out_valid8, out_last8;
  logic [7:0]  out_data8;
  logic [1:0]  out_lane8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  lane;
    logic [11:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];

  always #5 clock = ~clock;

  dsp_unpack_v4 #(.width(12)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last)
  );

  dsp_unpack_v4 #(.width(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .out_lane(out_lane8), .out_last(out_last8)
  );

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset at a point away from the clock edge; outputs must drop at once.
  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst out_valid", 48'(out_valid), 48'd0);
    check("rst in_ready", 48'(in_ready), 48'd1);
    check("rst out_data", 48'(out_data), 48'd0);
    check("rst out_lane", 48'(out_lane), 48'd0);
    check("rst out_last", 48'(out_last), 48'd0);
    check("rst out_valid w8", 48'(out_valid8), 48'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the lane queue, update it.
  task automatic step(input logic iv, input logic [47:0] d, input logic [3:0] m, input logic ordy);
    logic ev, er;
    exp_t e;
    @(negedge clock);
    in_valid  = iv;
    in_data   = d;
    in_mask   = m;
    out_ready = ordy;
    #1;
    ev = (q.size() != 0);
    er = (q.size() == 0) || (q.size() == 1 && ordy);
    check("in_ready", 48'(in_ready), 48'(er));
    check("out_valid", 48'(out_valid), 48'(ev));
    check("in_ready w8", 48'(in_ready8), 48'(er));
    check("out_valid w8", 48'(out_valid8), 48'(ev));
    if (ev) begin
      e = q[0];
      check("out_lane", 48'(out_lane), 48'(e.lane));
      check("out_last", 48'(out_last), 48'(e.last));
      check("out_data", 48'(out_data), 48'(e.data));
      check("out_data w8", 48'(out_data8), 48'(e.data[7:0]));
      check("out_lane w8", 48'(out_lane8), 48'(e.lane));
      check("out_last w8", 48'(out_last8), 48'(e.last));
      if (ordy) begin
        e = q.pop_front();
        $display("out lane=%0d data=%03h last=%0d", e.lane, e.data, e.last);
      end
    end
    if (iv && er) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          e.lane = 2'(i);
          e.data = d[12*i +: 12];
          e.last = (4'(m >> (i + 1)) == 4'd0);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle_steps(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 48'd0, 4'd0, ordy);
  endtask

  initial begin
    logic [47:0] rd;
    apply_reset();

    // Single word, all lanes.
    step(1'b1, {12'h004, 12'h003, 12'h002, 12'h001}, 4'hF, 1'b1);
    idle_steps(5, 1'b1);

    // Back-to-back words: second offered exactly on lane-3 cycle.
    step(1'b1, {12'h0D4, 12'h0C3, 12'h0B2, 12'h0A1}, 4'hF, 1'b1);
    idle_steps(3, 1'b1);
    step(1'b1, {12'h5D4, 12'h5C3, 12'h5B2, 12'h5A1}, 4'hF, 1'b1);
    idle_steps(4, 1'b1);

    // Sparse mask, then empty mask.
    step(1'b1, {12'h444, 12'h333, 12'h222, 12'h111}, 4'b1010, 1'b1);
    idle_steps(3, 1'b1);
    step(1'b1, {12'h777, 12'h666, 12'h555, 12'h999}, 4'h0, 1'b1);
    idle_steps(2, 1'b1);

    // Truncation on the 8-bit instance.
    step(1'b1, {12'h000, 12'h000, 12'hFFF, 12'hABC}, 4'b0011, 1'b1);
    idle_steps(3, 1'b1);

    // Stall with a competing input offered throughout.
    step(1'b1, {12'h0F4, 12'h0F3, 12'h0F2, 12'h0F1}, 4'hF, 1'b1);
    step(1'b1, 48'h123456789ABC, 4'hF, 1'b1);
    step(1'b1, 48'h123456789ABC, 4'hF, 1'b0);
    step(1'b1, 48'h123456789ABC, 4'hF, 1'b0);
    step(1'b1, 48'h123456789ABC, 4'hF, 1'b1);
    step(1'b0, 48'd0, 4'd0, 1'b0);
    step(1'b0, 48'd0, 4'd0, 1'b0);
    idle_steps(8, 1'b1);

    // Reset mid-word after lanes 0 and 1 have left.
    step(1'b1, {12'h3E4, 12'h3E3, 12'h3E2, 12'h3E1}, 4'hF, 1'b1);
    idle_steps(2, 1'b1);
    apply_reset();
    idle_steps(1, 1'b1);
    step(1'b1, {12'h010, 12'h020, 12'h030, 12'h040}, 4'b0100, 1'b1);
    idle_steps(2, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rd = {16'($urandom), 32'($urandom)};
      step(1'($urandom_range(0, 1)), rd, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end
    idle_steps(6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_unpack_v4.md
Name: dsp_unpack_v4

Overview:
- Consumer-side counterpart to the packed four-lane SIMD datapath: accepts one 48-bit packed DSP result word (four 12-bit lanes, lane i at bits [12*i+11:12*i]) through a valid/ready handshake.
- Emits the enabled lanes one at a time, lowest index first, on a narrow valid/ready stream.
- Sits between a FOUR12 SIMD DSP stage and scalar downstream logic (serial writeback, scalar FIFOs).

Parameters:
- width, 12: lane output width; legal range 1..12; out of range -> elaboration $error.

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  packed word and mask are valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  48  packed word, lane i = in_data[12*i +: 12]
- in_mask  input  4  lane enable; bit i=1 emits lane i
- out_valid  output  1  out_data/out_lane/out_last are valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  width  lane value = lane[width-1:0] (low bits, truncation)
- out_lane  output  2  index of the lane on out_data
- out_last  output  1  final enabled lane of the current word

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; data/mask holding registers=0.
  - in_ready=1, out_valid=0, out_data=0, out_lane=0, out_last=0.
- Handshakes:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - out_valid stays high and out_data/out_lane/out_last are held stable until transfer.
  - in_valid is not required to be stable.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Transfer with in_mask!=0: latch in_data and in_mask; go to EMIT with lane pointer = lowest set mask bit.
    - Transfer with in_mask=0: word is consumed silently; stay in IDLE; no output.
  - EMIT: out_valid=1, out_data=held lane[pointer][width-1:0], out_lane=pointer.
    - out_last=1 iff no set mask bit above pointer.
    - Output transfer with out_last=0: pointer advances to the next set mask bit; skipped lanes take no cycles.
    - Output transfer with out_last=1: word is done.
- in_ready in EMIT = out_last && out_ready (combinational), so words pass back-to-back with no bubble.
  - Last-lane transfer plus input transfer with in_mask!=0 in the same cycle: load the new word and stay in EMIT at its lowest set lane.
  - Last-lane transfer with no input transfer, or with an input transfer where in_mask=0: go to IDLE.
- Latency: an input accepted in cycle t gives its first out_valid in cycle t+1.
- Throughput: with out_ready held at 1, one lane per cycle sustained. A word with k enabled lanes occupies exactly k cycles.
- Backpressure: out_ready=0 freezes all state and outputs; in_ready=0 in EMIT unless the last lane is transferring.
- Reset mid-word: the held word is discarded and the block returns to IDLE immediately. No partial lanes are emitted after reset release.
- No arithmetic is performed. Lane bits above width are dropped, matching the lane slicing used by the SIMD adder outputs.

Test Plan:
- Reset, then one word with lanes 0x001/0x002/0x003/0x004, mask=4'hF, out_ready=1 -> out (lane, data) = (0,0x001),(1,0x002),(2,0x003),(3,0x004) on cycles t+1..t+4; out_last only on lane 3; in_ready high again in cycle t+4.
- Two words back-to-back, mask=4'hF, out_ready=1 -> 8 consecutive out_valid cycles, no bubble; second word accepted in the cycle of the first word's lane-3 transfer.
- mask=4'b1010, lanes 0x111,0x222,0x333,0x444 -> exactly two outputs, (1,0x222) then (3,0x444,last=1). mask=4'h0 -> accepted in one cycle, no out_valid.
- width=8, lane0=0xABC -> out_data=0xBC; a lane of 0xFFF -> 0xFF.
- out_ready toggled 1,0,0,1 during EMIT -> outputs held stable while stalled; no lane lost or duplicated; in_ready=0 throughout the stall.
- reset asserted after lane 1 of a mask=4'hF word -> out_valid=0 the same cycle. After release, in_ready=1; the next word starts at its own lowest set lane.
